conv_weight_packer: RTL and testbench

Consumes the serial coefficient stream produced by a layer's weight ROM streamer and repacks it into whole kernels presented in parallel to the convolution MAC array. Each packed kernel is replayed a fixed number of times, once per output pixel of a tile. Two kernel banks are ping-ponged, so the next kernel fills while the current one is being replayed. Sits between the weight streamer's FIFO and the conv datapath's kernel port.

---
 rtl/conv_weight_packer_pkg.sv | 14 +
 rtl/conv_weight_packer_if.sv | 24 ++
 rtl/conv_weight_packer_kern_bank.sv | 34 +++
 rtl/conv_weight_packer.sv | 81 ++++++++
 tb/tb_conv_weight_packer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/conv_weight_packer_pkg.sv
// Shared defaults and sizing helpers for the conv weight packer.
// Per-layer kernel size and reuse defaults live here alongside the coefficient width.
package conv_weight_packer_pkg;

    localparam int COEFF_WIDTH = 8;
    localparam int KERN_N_4    = 9;
    localparam int REUSE_4     = 4;

    // Counter width for a 0..n-1 counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_weight_packer_if.sv
// Upstream ap_fifo read port plus the parallel kernel port toward the MAC array.
interface conv_weight_packer_if #(
    parameter int COEFF_W = 8,
    parameter int KERN_N  = 9
);
    logic [COEFF_W-1:0]        input_V_dout;
    logic                      input_V_empty_n;
    logic                      input_V_read;
    logic [KERN_N*COEFF_W-1:0] kern_data;
    logic                      kern_valid;
    logic                      kern_ready;
    logic                      kern_last;
    logic                      busy;

    modport slave (
        input  input_V_dout, input_V_empty_n, kern_ready,
        output input_V_read, kern_data, kern_valid, kern_last, busy
    );

    modport master (
        output input_V_dout, input_V_empty_n, kern_ready,
        input  input_V_read, kern_data, kern_valid, kern_last, busy
    );
endinterface

// File: rtl/conv_weight_packer_kern_bank.sv
// One kernel bank: indexed coefficient write, full flag, flat packed read.
module kern_bank
    import conv_weight_packer_pkg::*;
#(
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int KERN_N  = KERN_N_4,
    localparam int FW     = cnt_w(KERN_N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [FW-1:0]             wr_idx,
    input  logic [COEFF_W-1:0]        wr_data,
    input  logic                      set_full,
    input  logic                      clr_full,
    output logic                      full,
    output logic [KERN_N*COEFF_W-1:0] rd_data
);
    logic [KERN_N-1:0][COEFF_W-1:0] regs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
            full <= 1'b0;
        end else begin
            if (wr_en) regs[wr_idx] <= wr_data;
            // set and clear never coincide; set wins defensively
            if (set_full)      full <= 1'b1;
            else if (clr_full) full <= 1'b0;
        end
    end

    assign rd_data = regs;
endmodule

// File: rtl/conv_weight_packer.sv
// Serial coefficient stream to parallel kernels, replayed REUSE times each,
// with two ping-ponged banks so the next kernel fills during replay.
module conv_weight_packer
    import conv_weight_packer_pkg::*;
#(
    parameter int COEFF_W = COEFF_WIDTH,
    parameter int KERN_N  = KERN_N_4,
    parameter int REUSE   = REUSE_4
) (
    input logic                 ap_clk,
    input logic                 ap_rst,
    conv_weight_packer_if.slave bus
);
    localparam int FW = cnt_w(KERN_N);
    localparam int RW = cnt_w(REUSE);
    localparam int KW = KERN_N * COEFF_W;
    localparam logic [FW-1:0] FILL_MAX = FW'(KERN_N - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REUSE - 1);

    logic            wr_sel, rd_sel;
    logic [FW-1:0]   fill_cnt;
    logic [RW-1:0]   rep_cnt;
    logic [1:0]      full;
    logic [1:0][KW-1:0] bank_data;

    logic rd, fill_done, accept, drain_done;

    assign rd         = bus.input_V_empty_n & ~full[wr_sel] & ~ap_rst;
    assign fill_done  = rd & (fill_cnt == FILL_MAX);
    assign accept     = bus.kern_valid & bus.kern_ready;
    assign drain_done = accept & bus.kern_last;

    assign bus.input_V_read = rd;
    assign bus.kern_valid   = full[rd_sel];
    assign bus.kern_data    = bank_data[rd_sel];
    assign bus.kern_last    = full[rd_sel] & (rep_cnt == REP_MAX);
    assign bus.busy         = (|full) | (fill_cnt != '0);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        kern_bank #(.COEFF_W(COEFF_W), .KERN_N(KERN_N)) u_bank (
            .clk      (ap_clk),
            .rst      (ap_rst),
            .wr_en    (rd & (wr_sel == 1'(b))),
            .wr_idx   (fill_cnt),
            .wr_data  (bus.input_V_dout),
            .set_full (fill_done & (wr_sel == 1'(b))),
            .clr_full (drain_done & (rd_sel == 1'(b))),
            .full     (full[b]),
            .rd_data  (bank_data[b])
        );
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_sel   <= 1'b0;
            fill_cnt <= '0;
        end else if (rd) begin
            if (fill_done) begin
                fill_cnt <= '0;
                wr_sel   <= ~wr_sel;
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // Handing off on the final accepted replay lets the other bank present next cycle.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rd_sel  <= 1'b0;
            rep_cnt <= '0;
        end else if (accept) begin
            if (drain_done) begin
                rep_cnt <= '0;
                rd_sel  <= ~rd_sel;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv_weight_packer.sv
// Scoreboard bench: kernels are queued as coefficients are read and compared on each emission.
module tb_conv_weight_packer;
    localparam int COEFF_W = 8;
    localparam int KERN_N  = 9;
    localparam int REUSE   = 4;
    localparam int KW      = KERN_N * COEFF_W;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    conv_weight_packer_if #(.COEFF_W(COEFF_W), .KERN_N(KERN_N)) bus ();

    conv_weight_packer #(.COEFF_W(COEFF_W), .KERN_N(KERN_N), .REUSE(REUSE)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    int n_chk = 0, n_pass = 0;
    logic [KW-1:0] exp_q[$];
    logic [KW-1:0] part = '0;
    int part_n = 0, rep = 0;
    logic [COEFF_W-1:0] coeff_nxt = 8'd1;
    int cyc = 0, fill_cyc = 0, first_vld = -1;
    int emits = 0, lasts = 0, reads = 0;
    int emit_cyc[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    task automatic clr_stats();
        emits = 0; lasts = 0; reads = 0; first_vld = -1;
        emit_cyc.delete();
    endtask

    task automatic tick(input logic en, input logic rdy);
        @(negedge ap_clk);
        bus.input_V_dout    = coeff_nxt;
        bus.input_V_empty_n = en;
        bus.kern_ready      = rdy;
        #1;
        chk("rd", bus.input_V_read, en && exp_q.size() < 2);
        chk("vld", bus.kern_valid, exp_q.size() > 0);
        chk("busy", bus.busy, exp_q.size() > 0 || part_n > 0);
        if (bus.kern_valid && first_vld < 0) first_vld = cyc;
        if (bus.kern_valid && exp_q.size() > 0) begin
            chk("data", bus.kern_data, exp_q[0]);
            chk("last", bus.kern_last, rep == REUSE - 1);
            if (rdy) begin
                emits++;
                emit_cyc.push_back(cyc);
                if (bus.kern_last) lasts++;
                rep++;
                if (rep == REUSE) begin
                    void'(exp_q.pop_front());
                    rep = 0;
                end
            end
        end
        if (bus.input_V_read) begin
            part[part_n*COEFF_W +: COEFF_W] = coeff_nxt;
            part_n++;
            reads++;
            coeff_nxt++;
            if (part_n == KERN_N) begin
                exp_q.push_back(part);
                part = '0;
                part_n = 0;
                fill_cyc = cyc;
            end
        end
        cyc++;
    endtask

    task automatic drain(input bit toggle);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1'b0, toggle ? 1'(i % 2) : 1'b1);
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        bus.input_V_empty_n = 1'b1;
        bus.kern_ready = 1'b1;
        #1;
        chk("rst_rd", bus.input_V_read, 1'b0);
        chk("rst_vld", bus.kern_valid, 1'b0);
        chk("rst_last", bus.kern_last, 1'b0);
        chk("rst_data", bus.kern_data, '0);
        chk("rst_busy", bus.busy, 1'b0);
        exp_q.delete();
        part = '0; part_n = 0; rep = 0;
        @(negedge ap_clk);
        bus.input_V_empty_n = 1'b0;
        ap_rst = 1'b0;
    endtask

    initial begin
        bus.input_V_dout = '0;
        bus.input_V_empty_n = 1'b0;
        bus.kern_ready = 1'b0;
        do_reset();

        // single kernel
        clr_stats();
        for (int i = 0; i < KERN_N; i++) tick(1'b1, 1'b1);
        drain(1'b0);
        chk("lat", 32'(first_vld), 32'(fill_cyc + 1));
        chk("single_emits", 32'(emits), 32'd4);
        chk("single_lasts", 32'(lasts), 32'd1);

        // ping-pong: second kernel fills while the first replays
        clr_stats();
        for (int i = 0; i < 60 && reads < 2*KERN_N; i++) tick(1'b1, reads >= 14);
        drain(1'b0);
        chk("pp_emits", 32'(emits), 32'd8);
        chk("pp_gap", emit_cyc.size() >= 5 ? 32'(emit_cyc[4] - emit_cyc[3]) : 32'hdead, 32'd1);

        // back-pressure
        clr_stats();
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
        chk("bp_reads", 32'(reads), 32'd18);
        chk("bp_busy", bus.busy, 1'b1);
        drain(1'b0);
        chk("bp_emits", 32'(emits), 32'd8);

        // stalled consumer
        clr_stats();
        for (int i = 0; i < 80 && reads < 2*KERN_N; i++) tick(1'b1, 1'(i % 2));
        drain(1'b1);
        chk("stall_emits", 32'(emits), 32'd8);
        chk("stall_lasts", 32'(lasts), 32'd2);

        // sparse upstream
        clr_stats();
        for (int i = 0; i < 60 && reads < KERN_N; i++) tick(i % 3 == 0, 1'b1);
        drain(1'b0);
        chk("sparse_emits", 32'(emits), 32'd4);

        // reset mid-fill
        clr_stats();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        chk("mid_part", 32'(part_n), 32'd5);
        do_reset();
        clr_stats();
        for (int i = 0; i < KERN_N; i++) tick(1'b1, 1'b1);
        drain(1'b0);
        chk("post_rst_emits", 32'(emits), 32'd4);
        chk("post_rst_lasts", 32'(lasts), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
